// File: rtl/uart_cmd_wrapper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_cmd_wrapper - pairs UART bytes into 16-bit commands, sends one  |
// | response byte. Option macro: CMD_TIMEOUT_EN.          Rev 1.0        |
// +----------------------------------------------------------------------+
module uart_cmd_wrapper #(
  parameter int TIMEOUT = 262144
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        snd_resp,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        resp_sent,
  output logic        sync_err
);

  typedef enum logic [0:0] {RX_HIGH = 1'b0, RX_LOW  = 1'b1} rx_state_t;
  typedef enum logic [0:0] {TX_IDLE = 1'b0, TX_BUSY = 1'b1} tx_state_t;

  if (TIMEOUT < 2 || TIMEOUT > (1 << 20)) begin : g_timeout_range_err
    $error("uart_cmd_wrapper: TIMEOUT must be within 2..2^20");
  end

  rx_state_t   r_rx_state;
  tx_state_t   r_tx_state;
  logic [7:0]  r_high;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;
  logic [7:0]  r_tx_data;
  logic        r_trmt;
  logic        r_resp_sent;

  // Receiver is never acknowledged while held in reset.
  assign clr_rx_rdy = rx_rdy & rst_n;

`ifdef CMD_TIMEOUT_EN
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT - 1);
  logic [19:0] r_tmr;
  logic        r_sync_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_HIGH;
      r_high     <= 8'h00;
      r_cmd      <= 16'h0000;
      r_cmd_rdy  <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      r_tmr      <= 20'd0;
      r_sync_err <= 1'b0;
`endif
    end else begin
      if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      r_sync_err <= 1'b0;
`endif
      case (r_rx_state)
        RX_HIGH: begin
          if (rx_rdy) begin
            r_high     <= rx_data;
            r_cmd_rdy  <= 1'b0;
            r_rx_state <= RX_LOW;
`ifdef CMD_TIMEOUT_EN
            r_tmr      <= 20'd0;
`endif
          end
        end
        RX_LOW: begin
          // Capture overrides a coincident clr_cmd_rdy and a coincident expiry.
          if (rx_rdy) begin
            r_cmd      <= {r_high, rx_data};
            r_cmd_rdy  <= 1'b1;
            r_rx_state <= RX_HIGH;
          end
`ifdef CMD_TIMEOUT_EN
          else if (r_tmr == TMO_LAST) begin
            r_rx_state <= RX_HIGH;
            r_sync_err <= 1'b1;
          end else begin
            r_tmr <= r_tmr + 20'd1;
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state  <= TX_IDLE;
      r_tx_data   <= 8'h00;
      r_trmt      <= 1'b0;
      r_resp_sent <= 1'b0;
    end else begin
      r_trmt      <= 1'b0;
      r_resp_sent <= 1'b0;
      case (r_tx_state)
        TX_IDLE: begin
          if (snd_resp) begin
            r_tx_data  <= resp;
            r_trmt     <= 1'b1;
            r_tx_state <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          // Requests while busy are dropped, not queued.
          if (tx_done) begin
            r_resp_sent <= 1'b1;
            r_tx_state  <= TX_IDLE;
          end
        end
      endcase
    end
  end

  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign tx_data   = r_tx_data;
  assign trmt      = r_trmt;
  assign resp_sent = r_resp_sent;
`ifdef CMD_TIMEOUT_EN
  assign sync_err  = r_sync_err;
`else
  assign sync_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_wrapper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_cmd_wrapper - directed scoreboard bench for uart_cmd_wrapper |
// | Timeout steps follow CMD_TIMEOUT_EN.                  Rev 1.0        |
// +----------------------------------------------------------------------+
module tb_uart_cmd_wrapper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        snd_resp = 1'b0;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done = 1'b0;
  logic        resp_sent;
  logic        sync_err;

  int n_err = 0;
  int n_chk = 0;
  int n_clr = 0;
  int n_trmt = 0;
  int n_sent = 0;

  logic [15:0] exp_cmd[$];
  logic [7:0]  exp_tx[$];

  uart_cmd_wrapper #(.TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .snd_resp(snd_resp),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .resp_sent(resp_sent), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr_rx_rdy) n_clr++;
    if (trmt) n_trmt++;
    if (resp_sent) n_sent++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One byte with rx_rdy high for a single cycle; the consume strobe must be immediate.
  task automatic rx_byte(input logic [7:0] b, input logic clr);
    rx_rdy = 1'b1;
    rx_data = b;
    clr_cmd_rdy = clr;
    #1;
    check("clr_rx_rdy_same_cycle", {31'd0, clr_rx_rdy}, 32'd1);
    step();
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic check_cmd(input string tag);
    logic [15:0] e;
    if (exp_cmd.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_cmd.pop_front();
      check({tag, "_rdy"}, {31'd0, cmd_rdy}, 32'd1);
      check(tag, {16'd0, cmd}, {16'd0, e});
    end
  endtask

  initial begin
    int c0;
    logic seen;

    // Reset with rx_rdy asserted: nothing may be consumed.
    rx_rdy = 1'b1;
    rx_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
    check("rst_cmd", {16'd0, cmd}, 32'h0);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'h0);
    check("rst_trmt", {31'd0, trmt}, 32'd0);
    check("rst_resp_sent", {31'd0, resp_sent}, 32'd0);
    check("rst_sync_err", {31'd0, sync_err}, 32'd0);
    rx_rdy = 1'b0;
    #2 rst_n = 1'b1;
    step();

    // Single command 2A,5C.
    c0 = n_clr;
    rx_byte(8'h2A, 1'b0);
    check("cmd_rdy_after_high", {31'd0, cmd_rdy}, 32'd0);
    exp_cmd.push_back(16'h2A5C);
    rx_byte(8'h5C, 1'b0);
    check_cmd("cmd_2a5c");
    check("clr_pulses_2", n_clr - c0, 32'd2);

    // Acknowledge clears cmd_rdy but cmd holds.
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    check("cmd_rdy_cleared", {31'd0, cmd_rdy}, 32'd0);
    check("cmd_hold", {16'd0, cmd}, 32'h2A5C);

    // Four back-to-back bytes; clr_cmd_rdy coincides with the first low capture.
    c0 = n_clr;
    rx_rdy = 1'b1;
    rx_data = 8'h11;
    step();
    exp_cmd.push_back(16'h1122);
    rx_data = 8'h22;
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    check_cmd("cmd_1122_set_wins");
    rx_data = 8'h33;
    step();
    check("cmd_rdy_drop_third", {31'd0, cmd_rdy}, 32'd0);
    check("cmd_stable_third", {16'd0, cmd}, 32'h1122);
    exp_cmd.push_back(16'h3344);
    rx_data = 8'h44;
    step();
    rx_rdy = 1'b0;
    check_cmd("cmd_3344");
    check("clr_pulses_4", n_clr - c0, 32'd4);

    // Response path, with a command received while transmitting.
    c0 = n_trmt;
    resp = 8'hA5;
    snd_resp = 1'b1;
    exp_tx.push_back(8'hA5);
    step();
    resp = 8'h3C;
    check("trmt_pulse", {31'd0, trmt}, 32'd1);
    check("tx_data_a5", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
    step();
    snd_resp = 1'b0;
    check("trmt_one_cycle", {31'd0, trmt}, 32'd0);
    rx_byte(8'h5A, 1'b0);
    check("no_trmt_busy", n_trmt - c0, 32'd1);
    check("tx_data_kept", {24'd0, tx_data}, 32'hA5);
    exp_cmd.push_back(16'h5AC3);
    rx_byte(8'hC3, 1'b0);
    check_cmd("cmd_5ac3_concurrent");
    c0 = n_sent;
    check("no_early_resp_sent", {31'd0, resp_sent}, 32'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("resp_sent_pulse", {31'd0, resp_sent}, 32'd1);
    step();
    step();
    check("resp_sent_single", n_sent - c0, 32'd1);

    // Silence after a high byte.
    rx_byte(8'h77, 1'b0);
    seen = 1'b0;
`ifdef CMD_TIMEOUT_EN
    for (int k = 1; k < 100; k++) begin
      step();
      if (sync_err) seen = 1'b1;
    end
    check("no_early_sync_err", {31'd0, seen}, 32'd0);
    step();
    check("sync_err_at_100", {31'd0, sync_err}, 32'd1);
    step();
    check("sync_err_one_cycle", {31'd0, sync_err}, 32'd0);
    check("cmd_unchanged_timeout", {16'd0, cmd}, 32'h5AC3);
`else
    for (int k = 1; k < 150; k++) begin
      step();
      if (sync_err) seen = 1'b1;
    end
    check("sync_err_never", {31'd0, seen}, 32'd0);
    exp_cmd.push_back(16'h7712);
    rx_byte(8'h12, 1'b0);
    check_cmd("cmd_7712_no_timeout");
`endif
    exp_cmd.push_back(16'h1234);
    rx_byte(8'h12, 1'b0);
    rx_byte(8'h34, 1'b0);
    check_cmd("cmd_1234");

    // Reset in LOW and while transmitting.
    snd_resp = 1'b1;
    resp = 8'h5E;
    exp_tx.push_back(8'h5E);
    rx_byte(8'hEE, 1'b0);
    snd_resp = 1'b0;
    check("tx_data_5e", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
    rst_n = 1'b0;
    #1;
    check("async_rst_cmd", {16'd0, cmd}, 32'h0);
    check("async_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    c0 = n_sent;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    check("no_resp_sent_after_rst", n_sent - c0, 32'd0);
    exp_cmd.push_back(16'hABCD);
    rx_byte(8'hAB, 1'b0);
    rx_byte(8'hCD, 1'b0);
    check_cmd("cmd_abcd_after_rst");
    check("scoreboard_drained", exp_cmd.size() + exp_tx.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
